instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/isa_pkg.sv | 56 +++++
 rtl/instr_fifo.sv | 78 +++++++
 rtl/instr_encoder.sv | 155 +++++++++++++++
 tb/tb_instr_encoder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// -----------------------------------------------------------------------------
// isa_pkg
// Shared instruction-set definitions: opcode constants, field widths and bit
// positions of the 32-bit instruction word, the encoder FSM state type, and
// helpers to check an opcode for legality and to pack the fields into a word.
// Word layout: [31:26] op, [25:23] rd, [22:20] r1, [19:17] r2,
//              [16:9] i1, [8:1] i2, [0] always 0.
// -----------------------------------------------------------------------------
package isa_pkg;

    localparam int OP_W   = 6;
    localparam int REG_W  = 3;
    localparam int IMM_W  = 8;
    localparam int WORD_W = 32;

    localparam logic [OP_W-1:0] OP_NOP   = 6'b000000;
    localparam logic [OP_W-1:0] OP_SUMA  = 6'b000001;
    localparam logic [OP_W-1:0] OP_RESTA = 6'b000010;

    localparam int OP_LSB = 26;
    localparam int RD_LSB = 23;
    localparam int R1_LSB = 20;
    localparam int R2_LSB = 17;
    localparam int I1_LSB = 9;
    localparam int I2_LSB = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    function automatic logic is_legal(input logic [OP_W-1:0] op);
        return (op == OP_NOP) || (op == OP_SUMA) || (op == OP_RESTA);
    endfunction

    function automatic logic [WORD_W-1:0] encode(
        input logic [OP_W-1:0]  op,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] r1,
        input logic [REG_W-1:0] r2,
        input logic [IMM_W-1:0] i1,
        input logic [IMM_W-1:0] i2
    );
        logic [WORD_W-1:0] w;
        w = '0;
        w[OP_LSB +: OP_W]  = op;
        w[RD_LSB +: REG_W] = rd;
        w[R1_LSB +: REG_W] = r1;
        w[R2_LSB +: REG_W] = r2;
        w[I1_LSB +: IMM_W] = i1;
        w[I2_LSB +: IMM_W] = i2;
        return w;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// -----------------------------------------------------------------------------
// instr_fifo
// Small synchronous FIFO holding encoded instruction words. The head word is
// visible combinationally on dout so the writer can present it the same cycle
// the entry becomes valid. Push and pop in the same cycle leave count unchanged.
// Ports:
//   clk, rst          clock, synchronous active-high reset (empties the FIFO)
//   push, din         write din when not full
//   pop               drop the head entry when not empty
//   dout              head entry (undefined content while empty)
//   full, empty       status flags
//   count             number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [PW:0]   count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_count == (PW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage is plain registers, no reset: contents are only observed
    // through entries that were written after reset.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (w_do_push && (r_wr_ptr == PW'(gi))) begin
                    r_mem[gi] <= din;
                end
            end
        end
    endgenerate

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Accepts instruction field tuples, encodes them into 32-bit words in a
// one-entry encode stage, queues legal words in instr_fifo and writes them to
// an instruction memory at consecutive addresses. Illegal opcodes are dropped
// and counted. The address counter wraps after the last address and sets a
// sticky mem_full flag that blocks new input until clr.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid / in_ready        input handshake for the field tuple
//   op, rd, r1, r2, i1, i2     instruction fields
//   mem_we / mem_ready         memory write handshake
//   mem_addr, mem_wdata        write address and encoded word
//   clr                        clears mem_full and the address counter
//   mem_full                   sticky "last address written" flag
//   err, err_cnt               illegal-opcode pulse and saturating count
// -----------------------------------------------------------------------------
module instr_encoder
    import isa_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [REG_W-1:0]  rd,
    input  logic [REG_W-1:0]  r1,
    input  logic [REG_W-1:0]  r2,
    input  logic [IMM_W-1:0]  i1,
    input  logic [IMM_W-1:0]  i2,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [AW-1:0]     mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              clr,
    output logic              mem_full,
    output logic              err,
    output logic [7:0]        err_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_stage_v;
    logic              r_stage_legal;
    logic [WORD_W-1:0] r_stage_word;
    logic [AW-1:0]     r_addr;
    logic [7:0]        r_err_cnt;

    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_wrap;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [WORD_W-1:0] w_fifo_head;
    logic [CW-1:0]     w_fifo_count;
    logic [CW-1:0]     w_occ;
    logic [CW-1:0]     w_cnt_next;
    logic              w_pending_next;

    // Occupancy includes the encode stage, which always empties into the FIFO
    // on the following edge; keeping one spare slot means that move never
    // needs to stall even when the memory is not accepting writes.
    assign w_occ    = w_fifo_count + CW'(r_stage_v);
    assign in_ready = (r_state != ST_FULL) && (w_occ < CW'(DEPTH - 1));
    assign w_accept = in_valid && in_ready;

    assign w_push   = r_stage_v && r_stage_legal && !w_fifo_full;
    assign mem_we   = !w_fifo_empty;
    assign w_pop    = mem_we && mem_ready;
    assign w_wrap   = w_pop && (r_addr == {AW{1'b1}});

    assign mem_addr  = r_addr;
    assign mem_wdata = w_fifo_empty ? '0 : w_fifo_head;
    assign mem_full  = (r_state == ST_FULL);
    assign err       = r_stage_v && !r_stage_legal;
    assign err_cnt   = r_err_cnt;

    // Anything left to write after this edge: a newly accepted tuple or FIFO
    // entries (a legal stage word is already counted via the push).
    assign w_cnt_next     = w_fifo_count + CW'(w_push) - CW'(w_pop);
    assign w_pending_next = w_accept || (w_cnt_next != '0);

    instr_fifo #(
        .DEPTH (DEPTH),
        .W     (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (r_stage_word),
        .pop   (w_pop),
        .dout  (w_fifo_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pending_next) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // clr on the wrap write wins: the flag never gets set.
                if (w_wrap && !clr) begin
                    w_state_next = ST_FULL;
                end else if (!w_pending_next) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_FULL: begin
                if (clr) begin
                    w_state_next = w_pending_next ? ST_RUN : ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_stage_v     <= 1'b0;
            r_stage_legal <= 1'b0;
            r_stage_word  <= '0;
            r_addr        <= '0;
            r_err_cnt     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_stage_v <= w_accept;
            if (w_accept) begin
                r_stage_word  <= encode(op, rd, r1, r2, i1, i2);
                r_stage_legal <= is_legal(op);
            end
            if (clr) begin
                r_addr <= '0;
            end else if (w_pop) begin
                r_addr <= r_addr + AW'(1);
            end
            if (err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  op = '0;
    logic [2:0]  rd = '0, r1 = '0, r2 = '0;
    logic [7:0]  i1 = '0, i2 = '0;
    logic        mem_we;
    logic        mem_ready = 1'b1;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        clr = 1'b0;
    logic        mem_full;
    logic        err;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  mon_addr = '0;

    instr_encoder #(.DEPTH(4), .AW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rd(rd), .r1(r1), .r2(r2), .i1(i1), .i2(i2),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .clr(clr), .mem_full(mem_full),
        .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [5:0] o, input logic [2:0] d,
                                        input logic [2:0] a, input logic [2:0] b,
                                        input logic [7:0] x, input logic [7:0] y);
        return {o, d, a, b, x, y, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end else begin
            $display("check %s: %h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [5:0] o, input logic [2:0] d, input logic [2:0] a,
                        input logic [2:0] b, input logic [7:0] x, input logic [7:0] y,
                        input logic [31:0] expw);
        int n = 0;
        while (!in_ready && n < 64) begin
            step();
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready got 0 expected 1 (op=%h)", o);
        end else begin
            op = o; rd = d; r1 = a; r2 = b; i1 = x; i2 = y;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            if (o == 6'd0 || o == 6'd1 || o == 6'd2) exp_q.push_back(expw);
            $display("sent op=%h word=%h", o, expw);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || mem_we) && n < 1000) begin
            step();
            n++;
        end
        if (n >= 1000) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending got %0d expected 0", exp_q.size());
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_full", 32'(mem_full), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    endtask

    // Monitor: compares every completed write against the scoreboard.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_addr = '0;
            end else begin
                if (mem_we && mem_ready) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_write: got addr=%h data=%h expected no write", mem_addr, mem_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        if (mem_wdata !== e || mem_addr !== mon_addr) begin
                            bad++;
                            $display("FAIL mem_write: got addr=%h data=%h expected addr=%h data=%h",
                                     mem_addr, mem_wdata, mon_addr, e);
                        end else begin
                            $display("write addr=%h data=%h", mem_addr, mem_wdata);
                        end
                    end
                    mon_addr = mon_addr + 8'd1;
                end
                if (clr) mon_addr = '0;
            end
        end
    end

    initial begin
        logic [31:0] w0;
        int we_seen;

        // Reset
        step(); step();
        rst = 1'b0;
        chk_reset_vals();

        // Single SUMA: mem_we two cycles after acceptance
        send(6'd1, 3'd3, 3'd1, 3'd2, 8'h12, 8'h34, 32'h05942468);
        chk("suma_we_early", 32'(mem_we), 32'd0);
        step();
        chk("suma_we", 32'(mem_we), 32'd1);
        chk("suma_addr", 32'(mem_addr), 32'd0);
        chk("suma_wdata", mem_wdata, 32'h05942468);
        drain();
        send(6'd1, 3'd5, 3'd5, 3'd2, 8'h12, 8'h34, 32'h06D42468);
        send(6'd2, 3'd7, 3'd0, 3'd4, 8'hFF, 8'h01, 32'h0B89FE02);
        drain();

        // Illegal opcode
        send(6'h3F, 3'd1, 3'd1, 3'd1, 8'h01, 8'h01, 32'd0);
        chk("err_pulse", 32'(err), 32'd1);
        step();
        chk("err_end", 32'(err), 32'd0);
        chk("err_cnt_1", 32'(err_cnt), 32'd1);
        we_seen = 0;
        for (int k = 0; k < 5; k++) begin
            if (mem_we) we_seen++;
            step();
        end
        chk("err_no_write", 32'(we_seen), 32'd0);

        // Backpressure with 5 tuples
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(6'(i % 3), 3'(i), 3'(i + 1), 3'(7 - i), 8'(8'h10 * i + 1), 8'(8'hA0 + i),
                 enc(6'(i % 3), 3'(i), 3'(i + 1), 3'(7 - i), 8'(8'h10 * i + 1), 8'(8'hA0 + i)));
        step(); step();
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_we", 32'(mem_we), 32'd1);
        w0 = enc(6'd0, 3'd0, 3'd1, 3'd7, 8'h01, 8'hA0);
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold_data", mem_wdata, w0);
            chk("bp_hold_addr", 32'(mem_addr), 32'd3);
            step();
        end
        mem_ready = 1'b1;
        for (int i = 3; i < 5; i++)
            send(6'(i % 3), 3'(i), 3'(i + 1), 3'(7 - i), 8'(8'h10 * i + 1), 8'(8'hA0 + i),
                 enc(6'(i % 3), 3'(i), 3'(i + 1), 3'(7 - i), 8'(8'h10 * i + 1), 8'(8'hA0 + i)));
        drain();

        // Reset with words pending
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(6'd0, 3'(i), 3'd0, 3'd0, 8'(i), 8'd0, enc(6'd0, 3'(i), 3'd0, 3'd0, 8'(i), 8'd0));
        step();
        rst = 1'b1;
        exp_q.delete();
        step(); step();
        rst = 1'b0;
        mem_ready = 1'b1;
        chk_reset_vals();
        we_seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (mem_we) we_seen++;
            step();
        end
        chk("rst_no_write", 32'(we_seen), 32'd0);

        // 256 NOP writes: wrap and mem_full
        for (int i = 0; i < 256; i++)
            send(6'd0, 3'(i), 3'(i >> 3), 3'(i >> 6), 8'(i), 8'(~i),
                 enc(6'd0, 3'(i), 3'(i >> 3), 3'(i >> 6), 8'(i), 8'(~i)));
        drain();
        chk("wrap_full", 32'(mem_full), 32'd1);
        chk("wrap_addr", 32'(mem_addr), 32'd0);
        chk("wrap_in_ready", 32'(in_ready), 32'd0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_full", 32'(mem_full), 32'd0);
        chk("clr_in_ready", 32'(in_ready), 32'd1);

        // clr together with a completing write
        send(6'd1, 3'd1, 3'd2, 3'd3, 8'hAA, 8'h55, enc(6'd1, 3'd1, 3'd2, 3'd3, 8'hAA, 8'h55));
        drain();
        mem_ready = 1'b0;
        send(6'd2, 3'd2, 3'd3, 3'd4, 8'h11, 8'h22, enc(6'd2, 3'd2, 3'd3, 3'd4, 8'h11, 8'h22));
        send(6'd1, 3'd6, 3'd5, 3'd4, 8'h33, 8'h44, enc(6'd1, 3'd6, 3'd5, 3'd4, 8'h33, 8'h44));
        chk("clrw_addr_before", 32'(mem_addr), 32'd1);
        clr = 1'b1;
        mem_ready = 1'b1;
        step();
        clr = 1'b0;
        chk("clrw_addr_zero", 32'(mem_addr), 32'd0);
        chk("clrw_full", 32'(mem_full), 32'd0);
        drain();
        chk("clrw_addr_after", 32'(mem_addr), 32'd1);

        // err_cnt saturation
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 256; i++)
            send(6'(3 + (i % 61)), 3'd0, 3'd0, 3'd0, 8'(i), 8'd0, 32'd0);
        step(); step(); step();
        chk("err_sat", 32'(err_cnt), 32'd255);
        send(6'h3F, 3'd0, 3'd0, 3'd0, 8'd0, 8'd0, 32'd0);
        step(); step(); step();
        chk("err_sat_hold", 32'(err_cnt), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
